// File: rtl/core_pkg.sv
// Shared instruction-fetch types and constants for the core and its memory responders.
package core_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic              err;
        logic [INST_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-latency response shift register; payload only moves with its valid bit,
// so the final stage holds the last delivered response while idle.
module imem_resp_pipe
    import core_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  head_valid,
    input  resp_t head_resp,
    output logic  tail_valid,
    output resp_t tail_resp
);

    logic  [LATENCY-1:0] vld;
    resp_t               stg [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg[i] <= '0;
            end
        end else begin
            vld[0] <= head_valid;
            if (head_valid) begin
                stg[0] <= head_resp;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    stg[i] <= stg[i-1];
                end
            end
        end
    end

    assign tail_valid = vld[LATENCY-1];
    assign tail_resp  = stg[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction memory behind the core fetch handshake: in-order responses after LATENCY
// cycles, bounded outstanding count, and a write-only preload port with priority.
module imem_responder
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              inst_req_i,
    input  logic [31:0]       inst_addr_i,
    output logic              inst_grnt_o,
    output logic [INST_W-1:0] inst_data_o,
    output logic              inst_valid_o,
    output logic              inst_err_o,
    input  logic              load_we_i,
    input  logic [31:0]       load_addr_i,
    input  logic [31:0]       load_data_i
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [INST_W-1:0] mem [DEPTH_WORDS];
    logic [CW-1:0]     out_cnt;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic              rd_err;
    logic              ld_ok;
    logic              grant;
    resp_t             rd_resp;
    resp_t             tail_resp;

    assign rd_idx = inst_addr_i[AW+1:2];
    assign wr_idx = load_addr_i[AW+1:2];
    assign rd_err = (inst_addr_i[1:0] != 2'b00) || (inst_addr_i[31:AW+2] != '0);
    assign ld_ok  = load_we_i && (load_addr_i[1:0] == 2'b00) && (load_addr_i[31:AW+2] == '0);

    // Loads win the cycle, so the array never sees a read and write together.
    assign grant       = inst_req_i && !load_we_i && (out_cnt < CW'(MAX_OUTSTANDING));
    assign inst_grnt_o = grant;

    assign rd_resp.err  = rd_err;
    assign rd_resp.data = rd_err ? '0 : mem[rd_idx];

    always_ff @(posedge clk_i) begin
        if (ld_ok) begin
            mem[wr_idx] <= load_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            out_cnt <= '0;
        end else begin
            case ({grant, inst_valid_o})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    imem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk        (clk_i),
        .rst        (arst_i),
        .head_valid (grant),
        .head_resp  (rd_resp),
        .tail_valid (inst_valid_o),
        .tail_resp  (tail_resp)
    );

    assign inst_data_o = tail_resp.data;
    assign inst_err_o  = tail_resp.err;

endmodule
